gen_ram_wradd: RTL and testbench

Write-side address and bank controller for the two ping-pong line RAMs (A/B) in the CCD edge-detection datapath. It accepts the incoming pixel stream, generates the write enable and write address for one line RAM at a time, and alternates banks at every line boundary. It reports completed lines and bank identity so the read-address side can replay the previous line. It is the counterpart of the read-address generator on the same RAM pair.

---
 rtl/gen_ram_pkg.sv | 31 +++
 rtl/gen_ram_colcnt.sv | 48 ++++
 rtl/gen_ram_wradd.sv | 170 +++++++++++++++++
 tb/tb_gen_ram_wradd.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gen_ram_pkg.sv
// ============================================================================
// Module      : gen_ram_pkg
// Description : Types and widths shared by the line-RAM read/write address
//               generators of the edge-detection datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gen_ram_pkg;

    localparam int ADDR_W = 11;
    localparam int ROW_W  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_A = 2'd1,
        WR_B = 2'd2
    } wr_state_t;

    // Bank identity as reported on last_bank: 0 = RAM A, 1 = RAM B.
    function automatic logic bank_of(input wr_state_t s);
        return (s == WR_B);
    endfunction

    function automatic wr_state_t other_bank(input wr_state_t s);
        return (s == WR_A) ? WR_B : WR_A;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gen_ram_colcnt.sv
// ============================================================================
// Module      : gen_ram_colcnt
// Description : Column counter with enable, synchronous clear and a
//               terminal-count flag at column_size-1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gen_ram_colcnt
    import gen_ram_pkg::*;
#(
    parameter int column_size = 1280
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              i_en,
    input  logic              i_clr,
    output logic [ADDR_W-1:0] o_cur,
    output logic              o_tc
);

    localparam logic [ADDR_W-1:0] C_COL_LAST = ADDR_W'(column_size - 1);

    logic [ADDR_W-1:0] r_cnt_q;
    logic [ADDR_W-1:0] w_cnt_d;

    // o_cur is the column this cycle's pixel lands on: a clear coinciding
    // with an enable counts the pixel as column 0.
    always_comb begin
        o_cur   = i_clr ? '0 : r_cnt_q;
        o_tc    = (o_cur == C_COL_LAST);
        w_cnt_d = o_cur;
        if (i_en) begin
            w_cnt_d = o_tc ? '0 : o_cur + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/gen_ram_wradd.sv
// ============================================================================
// Module      : gen_ram_wradd
// Description : Write-side address/bank controller for the ping-pong line
//               RAMs A/B; alternates banks at every line boundary.
//               Optional macro GEN_RAM_WRADD_OVERRUN_EN enables the sticky
//               overrun flag for pixels arriving while idle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gen_ram_wradd
    import gen_ram_pkg::*;
#(
    parameter int column_size = 1280,
    parameter int row_size    = 1024
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              frame_start,
    input  logic              pix_valid,
    output logic              rama_wren,
    output logic              ramb_wren,
    output logic [ADDR_W-1:0] rama_wradd,
    output logic [ADDR_W-1:0] ramb_wradd,
    output logic              line_done,
    output logic              last_bank,
    output logic [ROW_W-1:0]  row_cnt,
    output logic              frame_done,
    output logic              busy,
    output logic              overrun
);

    localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(row_size - 1);

    wr_state_t         r_state_q,      w_state_d;
    logic [ROW_W-1:0]  r_row_q,        w_row_d;
    logic              r_wren_a_q,     w_wren_a_d;
    logic              r_wren_b_q,     w_wren_b_d;
    logic [ADDR_W-1:0] r_wradd_a_q,    w_wradd_a_d;
    logic [ADDR_W-1:0] r_wradd_b_q,    w_wradd_b_d;
    logic              r_line_done_q,  w_line_done_d;
    logic              r_frame_done_q, w_frame_done_d;
    logic              r_last_bank_q,  w_last_bank_d;
    logic              r_busy_q,       w_busy_d;

    wr_state_t         w_cur_state;
    logic [ROW_W-1:0]  w_cur_row;
    logic              w_accept;
    logic [ADDR_W-1:0] w_col_cur;
    logic              w_col_tc;

    // frame_start overrides the current position, so a pixel arriving with
    // it is written as column 0, row 0, bank A regardless of prior state.
    assign w_cur_state = frame_start ? WR_A : r_state_q;
    assign w_cur_row   = frame_start ? '0   : r_row_q;
    assign w_accept    = pix_valid && (frame_start || (r_state_q != IDLE));

    gen_ram_colcnt #(
        .column_size (column_size)
    ) u_colcnt (
        .clk   (clk),
        .aclr  (aclr),
        .i_en  (w_accept),
        .i_clr (frame_start),
        .o_cur (w_col_cur),
        .o_tc  (w_col_tc)
    );

    always_comb begin
        w_state_d      = w_cur_state;
        w_row_d        = w_cur_row;
        w_last_bank_d  = frame_start ? 1'b0 : r_last_bank_q;
        w_wren_a_d     = 1'b0;
        w_wren_b_d     = 1'b0;
        w_wradd_a_d    = r_wradd_a_q;
        w_wradd_b_d    = r_wradd_b_q;
        w_line_done_d  = 1'b0;
        w_frame_done_d = 1'b0;

        if (w_accept) begin
            if (w_cur_state == WR_B) begin
                w_wren_b_d  = 1'b1;
                w_wradd_b_d = w_col_cur;
            end else begin
                w_wren_a_d  = 1'b1;
                w_wradd_a_d = w_col_cur;
            end

            if (w_col_tc) begin
                w_line_done_d = 1'b1;
                w_last_bank_d = bank_of(w_cur_state);
                if (w_cur_row == C_ROW_LAST) begin
                    w_frame_done_d = 1'b1;
                    w_row_d        = '0;
                    w_state_d      = IDLE;
                end else begin
                    w_row_d   = w_cur_row + ROW_W'(1);
                    w_state_d = other_bank(w_cur_state);
                end
            end
        end

        w_busy_d = (w_state_d != IDLE);
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_state_q      <= IDLE;
            r_row_q        <= '0;
            r_wren_a_q     <= 1'b0;
            r_wren_b_q     <= 1'b0;
            r_wradd_a_q    <= '0;
            r_wradd_b_q    <= '0;
            r_line_done_q  <= 1'b0;
            r_frame_done_q <= 1'b0;
            r_last_bank_q  <= 1'b0;
            r_busy_q       <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_row_q        <= w_row_d;
            r_wren_a_q     <= w_wren_a_d;
            r_wren_b_q     <= w_wren_b_d;
            r_wradd_a_q    <= w_wradd_a_d;
            r_wradd_b_q    <= w_wradd_b_d;
            r_line_done_q  <= w_line_done_d;
            r_frame_done_q <= w_frame_done_d;
            r_last_bank_q  <= w_last_bank_d;
            r_busy_q       <= w_busy_d;
        end
    end

`ifdef GEN_RAM_WRADD_OVERRUN_EN
    logic r_overrun_q;
    logic w_overrun_d;

    always_comb begin
        w_overrun_d = r_overrun_q;
        if (frame_start) begin
            w_overrun_d = 1'b0;
        end else if (pix_valid && (r_state_q == IDLE)) begin
            w_overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_overrun_q <= 1'b0;
        end else begin
            r_overrun_q <= w_overrun_d;
        end
    end

    assign overrun = r_overrun_q;
`else
    assign overrun = 1'b0;
`endif

    assign rama_wren  = r_wren_a_q;
    assign ramb_wren  = r_wren_b_q;
    assign rama_wradd = r_wradd_a_q;
    assign ramb_wradd = r_wradd_b_q;
    assign line_done  = r_line_done_q;
    assign frame_done = r_frame_done_q;
    assign last_bank  = r_last_bank_q;
    assign row_cnt    = r_row_q;
    assign busy       = r_busy_q;

endmodule

`default_nettype wire

// File: tb/tb_gen_ram_wradd.sv
// ============================================================================
// Module      : tb_gen_ram_wradd
// Description : Scoreboard bench for gen_ram_wradd with a pixel-index
//               reference model (12 columns x 10 rows).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gen_ram_wradd;

    localparam int COLS = 12;
    localparam int ROWS = 10;
`ifdef GEN_RAM_WRADD_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        aclr = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic        rama_wren, ramb_wren;
    logic [10:0] rama_wradd, ramb_wradd;
    logic        line_done, last_bank, frame_done, busy, overrun;
    logic [9:0]  row_cnt;

    gen_ram_wradd #(
        .column_size (COLS),
        .row_size    (ROWS)
    ) dut (
        .clk         (clk),
        .aclr        (aclr),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .rama_wren   (rama_wren),
        .ramb_wren   (ramb_wren),
        .rama_wradd  (rama_wradd),
        .ramb_wradd  (ramb_wradd),
        .line_done   (line_done),
        .last_bank   (last_bank),
        .row_cnt     (row_cnt),
        .frame_done  (frame_done),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wa;
        logic        wb;
        logic [10:0] aa;
        logic [10:0] ab;
        logic        ld;
        logic        fd;
        logic        lb;
        logic [9:0]  rc;
        logic        bz;
    } ev_t;

    ev_t q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    // Reference state: position in the frame as a linear pixel index.
    bit          m_act = 1'b0;
    int unsigned m_pidx = 0;
    bit          m_lb = 1'b0;
    logic [10:0] m_addr_a = '0;
    logic [10:0] m_addr_b = '0;
    bit          m_ovr = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 1'b0; m_pidx = 0; m_lb = 1'b0;
        m_addr_a = '0; m_addr_b = '0; m_ovr = 1'b0;
        q.delete();
    endtask

    task automatic model(input bit fs, input bit pv);
        int  line, col;
        ev_t e;
        if (fs) begin
            m_act = 1'b1; m_pidx = 0; m_lb = 1'b0; m_ovr = 1'b0;
        end
        if (pv && !m_act) m_ovr = 1'b1;
        if (pv && m_act) begin
            line = int'(m_pidx) / COLS;
            col  = int'(m_pidx) % COLS;
            e = '0;
            if (line % 2 == 1) begin e.wb = 1'b1; m_addr_b = 11'(col); end
            else               begin e.wa = 1'b1; m_addr_a = 11'(col); end
            e.aa = m_addr_a;
            e.ab = m_addr_b;
            e.ld = (col == COLS - 1);
            if (e.ld) m_lb = (line % 2 == 1);
            e.fd = (m_pidx == COLS * ROWS - 1);
            m_pidx++;
            if (e.fd) begin m_act = 1'b0; m_pidx = 0; end
            e.lb = m_lb;
            e.rc = 10'(m_pidx / COLS);
            e.bz = m_act;
            q.push_back(e);
        end
    endtask

    task automatic cycle(input bit fs, input bit pv);
        frame_start = fs;
        pix_valid   = pv;
        model(fs, pv);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_wren_a"}, 64'(rama_wren), 64'(0));
        chk({tag, "_wren_b"}, 64'(ramb_wren), 64'(0));
        chk({tag, "_wradd_a"}, 64'(rama_wradd), 64'(0));
        chk({tag, "_wradd_b"}, 64'(ramb_wradd), 64'(0));
        chk({tag, "_pulses"}, 64'({line_done, frame_done}), 64'(0));
        chk({tag, "_last_bank"}, 64'(last_bank), 64'(0));
        chk({tag, "_row_cnt"}, 64'(row_cnt), 64'(0));
        chk({tag, "_busy_ovr"}, 64'({busy, overrun}), 64'(0));
    endtask

    // Asserted mid-cycle, away from any edge, so the clear must be asynchronous.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #1;
        aclr = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
        model_reset();
        #1;
        check_reset_vals(tag);
        @(negedge clk);
        #1;
        aclr = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        chk({tag, "_busy"}, 64'(busy), 64'(m_act));
        chk({tag, "_row_cnt"}, 64'(row_cnt), 64'(m_pidx / COLS));
        chk({tag, "_last_bank"}, 64'(last_bank), 64'(m_lb));
        chk({tag, "_overrun"}, 64'(overrun), 64'(m_ovr & OVR_EN));
        chk({tag, "_pending"}, 64'(q.size()), 64'(0));
    endtask

    // Monitor: every write the DUT presents is matched against the scoreboard.
    always @(negedge clk) begin
        ev_t a, e;
        if (aclr) begin
            if (rama_wren || ramb_wren) begin
                a = '{rama_wren, ramb_wren, rama_wradd, ramb_wradd, line_done,
                      frame_done, last_bank, row_cnt, busy};
                n_checks++;
                if (q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_write: got %h expected none (t=%0t)", a, $time);
                end else begin
                    e = q.pop_front();
                    if (a !== e) begin
                        n_errors++;
                        $display("FAIL write_event: got wa=%b wb=%b aa=%0d ab=%0d ld=%b fd=%b lb=%b rc=%0d bz=%b expected wa=%b wb=%b aa=%0d ab=%0d ld=%b fd=%b lb=%b rc=%0d bz=%b (t=%0t)",
                                 a.wa, a.wb, a.aa, a.ab, a.ld, a.fd, a.lb, a.rc, a.bz,
                                 e.wa, e.wb, e.aa, e.ab, e.ld, e.fd, e.lb, e.rc, e.bz, $time);
                    end
                end
            end else begin
                n_checks++;
                if (line_done || frame_done) begin
                    n_errors++;
                    $display("FAIL idle_pulse: got ld=%b fd=%b expected 0 0 (t=%0t)",
                             line_done, frame_done, $time);
                end
            end
        end
    end

    initial begin
        #1;
        check_reset_vals("por");
        do_reset("reset0");

        // One line, bank A.
        cycle(1'b1, 1'b0);
        for (int i = 0; i < COLS; i++) cycle(1'b0, 1'b1);
        check_state("one_line");

        // Full frame of continuous pixels, first pixel with frame_start.
        cycle(1'b1, 1'b1);
        for (int i = 1; i < COLS * ROWS; i++) cycle(1'b0, 1'b1);
        check_state("full_frame");

        // Gapped pixels: one on, two off.
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, 1'b1);
            cycle(1'b0, 1'b0);
            cycle(1'b0, 1'b0);
        end
        check_state("gapped");

        // Abort at column 5, row 3.
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 3 * COLS + 5; i++) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 14; i++) cycle(1'b0, 1'b1);
        check_state("abort");

        // Finish the frame, then pixels in IDLE are dropped.
        for (int i = 14; i < COLS * ROWS; i++) cycle(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
        check_state("idle_drop");
        cycle(1'b1, 1'b0);
        check_state("ovr_clear");

        // Asynchronous reset at column 7, then a clean frame start.
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1);
        do_reset("aclr_mid");
        cycle(1'b1, 1'b0);
        for (int i = 0; i < COLS + 3; i++) cycle(1'b0, 1'b1);
        check_state("after_aclr");

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 149) == 0, $urandom_range(0, 9) < 7);
        end
        check_state("random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
